// File: rtl/baud_gen_frac_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the fractional baud generator:
//   - default widths, oversample ratio and reset divisor
//   - MIN_DIV: smallest usable integer divisor (shorter values are clamped)
//   - baud_div_t: an {integer, fraction} divisor pair
//   - baud_div_calc(): rounds clk_hz / (baud * ovs) to 1/2^FRAC_W resolution,
//     for firmware tables and reference values
// No ports (package).
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int BAUD_DIV_W    = 16;
    localparam int BAUD_FRAC_W   = 4;
    localparam int BAUD_OVS      = 16;
    localparam int BAUD_DEF_INT  = 651;
    localparam int BAUD_DEF_FRAC = 1;
    localparam int MIN_DIV       = 2;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_div_t;

    // Divisor in fixed point with BAUD_FRAC_W fraction bits, rounded to nearest.
    function automatic baud_div_t baud_div_calc(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input longint unsigned ovs);
        longint unsigned den;
        longint unsigned q;
        baud_div_t       r;
        den = baud * ovs;
        if (den == 0) begin
            r.div_int  = BAUD_DIV_W'(BAUD_DEF_INT);
            r.div_frac = BAUD_FRAC_W'(BAUD_DEF_FRAC);
        end else begin
            q          = ((clk_hz << BAUD_FRAC_W) + (den >> 1)) / den;
            r.div_int  = BAUD_DIV_W'(q >> BAUD_FRAC_W);
            r.div_frac = BAUD_FRAC_W'(q);
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// -----------------------------------------------------------------------------
// baud_gen_frac_if
// Connection between the register block (master) and the baud generator
// (slave).
//   en          master->slave  run enable
//   div_int     master->slave  integer divisor, sampled with div_load
//   div_frac    master->slave  fractional divisor, sampled with div_load
//   div_load    master->slave  one-cycle load strobe
//   div_ack     slave->master  one-cycle pulse: loaded divisor now active
//   os_tick     slave->master  oversample tick
//   bit_tick    slave->master  bit tick (coincides with an os_tick)
//   phase_sync  master->slave  only when BAUD_PHASE_SYNC_EN is defined
//
// Load handshake: div_load is a fire-and-forget valid with no ready; the
// generator always accepts it. Each accepted value (or run of overwriting
// values) is answered by exactly one div_ack pulse once it has taken effect.
// -----------------------------------------------------------------------------
interface baud_gen_frac_if #(
    parameter int DIV_W  = baud_pkg::BAUD_DIV_W,
    parameter int FRAC_W = baud_pkg::BAUD_FRAC_W
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_ack;
    logic              os_tick;
    logic              bit_tick;
`ifdef BAUD_PHASE_SYNC_EN
    logic              phase_sync;
`endif

    modport master (
`ifdef BAUD_PHASE_SYNC_EN
        output phase_sync,
`endif
        output en, div_int, div_frac, div_load,
        input  div_ack, os_tick, bit_tick
    );

    modport slave (
`ifdef BAUD_PHASE_SYNC_EN
        input  phase_sync,
`endif
        input  en, div_int, div_frac, div_load,
        output div_ack, os_tick, bit_tick
    );
endinterface

// File: rtl/baud_frac_div.sv
// -----------------------------------------------------------------------------
// baud_frac_div
// Fractional period counter. cnt runs 0..term with term = div_int-1+ext;
// at terminal count the fraction is added into acc and its carry stretches
// the following period by one clock, so div_frac out of every 2^FRAC_W
// periods are one clock longer.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   en        in   run enable; 0 clears the counter state
//   clr       in   phase clear; restarts a period with no tick
//   div_int   in   integer divisor, already clamped to >= 2
//   div_frac  in   fractional divisor
//   term_hit  out  combinational: this edge ends a period
//   os_tick   out  registered tick, high the cycle after terminal count
// -----------------------------------------------------------------------------
module baud_frac_div #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              term_hit,
    output logic              os_tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] term;
    logic [FRAC_W-1:0] acc;
    logic             ext;
    logic [FRAC_W:0]  sum;

    // div_int >= 2, so term >= 1 and cannot wrap.
    assign term     = div_int - DIV_W'(1) + DIV_W'(ext);
    assign sum      = {1'b0, acc} + {1'b0, div_frac};
    assign term_hit = en & ~clr & (cnt == term);

    always_ff @(posedge clk) begin
        if (!rst || !en || clr) begin
            cnt     <= '0;
            acc     <= '0;
            ext     <= 1'b0;
            os_tick <= 1'b0;
        end else if (cnt == term) begin
            cnt     <= '0;
            acc     <= sum[FRAC_W-1:0];
            ext     <= sum[FRAC_W];
            os_tick <= 1'b1;
        end else begin
            cnt     <= cnt + DIV_W'(1);
            os_tick <= 1'b0;
        end
    end
endmodule

// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
// Runtime-programmable fractional baud generator. os_tick has an average
// period of div_int + div_frac/2^FRAC_W clocks; bit_tick marks every OVS-th
// os_tick. A new divisor is held in a shadow and only switched in at a period
// boundary (or immediately while stopped), so no period is ever cut short.
// Optional feature macro: BAUD_PHASE_SYNC_EN adds bus.phase_sync, which
// restarts the period and bit phase (RX start-bit alignment).
// Ports:
//   clk   in      system clock
//   rst   in      synchronous active-low reset
//   bus   slave   en, div_int, div_frac, div_load, div_ack, os_tick,
//                 bit_tick [, phase_sync]
// -----------------------------------------------------------------------------
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DIV_W        = BAUD_DIV_W,
    parameter int FRAC_W       = BAUD_FRAC_W,
    parameter int OVS          = BAUD_OVS,
    parameter int DEF_DIV_INT  = BAUD_DEF_INT,
    parameter int DEF_DIV_FRAC = BAUD_DEF_FRAC
) (
    input  logic          clk,
    input  logic          rst,
    baud_gen_frac_if.slave bus
);
    localparam int OC_W = (OVS > 1) ? $clog2(OVS) : 1;

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic              pending;
    logic              ack_q;
    logic [DIV_W-1:0]  eff_int;
    logic              term_hit;
    logic              apply_now;
    logic              sync_clr;
    logic [OC_W-1:0]   os_cnt;
    logic              bit_q;

`ifdef BAUD_PHASE_SYNC_EN
    assign sync_clr = bus.en & bus.phase_sync;
`else
    assign sync_clr = 1'b0;
`endif

    assign eff_int = (act_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : act_int;

    // A divisor takes effect at a period boundary, or at once while stopped.
    // A load arriving on that very edge bypasses the shadow.
    assign apply_now = (pending | bus.div_load) & (term_hit | ~bus.en);

    baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .clr      (sync_clr),
        .div_int  (eff_int),
        .div_frac (act_frac),
        .term_hit (term_hit),
        .os_tick  (bus.os_tick)
    );

    // Shadow / active divisor and acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_int  <= DIV_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= '0;
            sh_frac  <= '0;
            pending  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= apply_now;
            if (apply_now) begin
                act_int  <= bus.div_load ? bus.div_int  : sh_int;
                act_frac <= bus.div_load ? bus.div_frac : sh_frac;
                pending  <= 1'b0;
            end else if (bus.div_load) begin
                sh_int   <= bus.div_int;
                sh_frac  <= bus.div_frac;
                pending  <= 1'b1;
            end
        end
    end

    // Oversample counter: bit_tick rides on the OVS-th os_tick.
    always_ff @(posedge clk) begin
        if (!rst || !bus.en || sync_clr) begin
            os_cnt <= '0;
            bit_q  <= 1'b0;
        end else if (term_hit) begin
            bit_q  <= (os_cnt == OC_W'(OVS - 1));
            os_cnt <= (os_cnt == OC_W'(OVS - 1)) ? '0 : os_cnt + OC_W'(1);
        end else begin
            bit_q  <= 1'b0;
        end
    end

    assign bus.div_ack  = ack_q;
    assign bus.bit_tick = bit_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
// Bench for baud_gen_frac. A reference model predicts, for every clock edge,
// whether os_tick / bit_tick / div_ack appear after it, using period lengths
// (div_int clamped to 2, plus one clock whenever the running sum of fractions
// passes 2^FRAC_W). Predictions go into exp_q; the monitor pops and compares
// whenever the DUT shows any output. Directed sections also measure tick
// spacing from recorded tick times against hand-derived numbers.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;
    import baud_pkg::*;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
    localparam int EV_W   = 35;   // {cycle[31:0], os, bit, ack}

    logic clk = 1'b0;
    logic rst;
    logic ps;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [EV_W-1:0] exp_q[$];
    int act_ticks[$];
    int act_bits[$];
    int act_acks[$];

    baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

`ifdef BAUD_PHASE_SYNC_EN
    assign bus.phase_sync = ps;
`endif

    baud_gen_frac #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .OVS          (OVS),
        .DEF_DIV_INT  (651),
        .DEF_DIV_FRAC (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int m_int, m_frac, m_sh_int, m_sh_frac;
    int m_acc, m_os, m_next;
    bit m_pend, m_run;

    function automatic int eff(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Predict what the upcoming edge (cyc+1) does with the inputs now applied.
    task automatic model_edge();
        int e;
        bit term, apply, bt, ld, c;
        int s;
        e = cyc + 1;
        term = 0; apply = 0; bt = 0; c = 0;
        if (!rst) begin
            m_int = 651; m_frac = 1; m_pend = 0; m_run = 0;
            m_acc = 0; m_os = 0;
            return;
        end
        ld = bus.div_load;
        if (!bus.en) begin
            apply = m_pend || ld;
            m_run = 0; m_acc = 0; m_os = 0;
        end else if (ps) begin
            m_run = 1; m_acc = 0; m_os = 0;
            m_next = e + eff(m_int);
        end else if (!m_run) begin
            m_run = 1;
            m_next = e + eff(m_int) - 1;
        end else if (e == m_next) begin
            term  = 1;
            apply = m_pend || ld;
        end
        if (term) begin
            s = m_acc + m_frac;
            c = (s >= (1 << FRAC_W));
            m_acc = s % (1 << FRAC_W);
            bt = (m_os == OVS - 1);
            m_os = bt ? 0 : m_os + 1;
        end
        if (apply) begin
            if (ld) begin m_int = int'(bus.div_int); m_frac = int'(bus.div_frac); end
            else    begin m_int = m_sh_int;          m_frac = m_sh_frac;          end
            m_pend = 0;
        end else if (ld) begin
            m_sh_int = int'(bus.div_int); m_sh_frac = int'(bus.div_frac); m_pend = 1;
        end
        if (term) m_next = e + eff(m_int) + int'(c);
        if (term || apply) exp_q.push_back({32'(e), term, bt, apply});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EV_W-1:0] a_ev;
        logic [EV_W-1:0] e_ev;
        bit due;
        a_ev = {32'(cyc), bus.os_tick, bus.bit_tick, bus.div_ack};
        due  = (exp_q.size() > 0) && (int'(exp_q[0][34:3]) <= cyc);
        if (a_ev[2:0] != 3'b000 || due) begin
            if (due) e_ev = exp_q.pop_front();
            else     e_ev = {32'(cyc), 3'b000};
            checks++;
            if (a_ev !== e_ev) begin
                failures++;
                $display("FAIL scoreboard: got cyc=%0d os/bit/ack=%b, expected cyc=%0d os/bit/ack=%b",
                         cyc, a_ev[2:0], e_ev[34:3], e_ev[2:0]);
            end
        end
        if (bus.os_tick  === 1'b1) act_ticks.push_back(cyc);
        if (bus.bit_tick === 1'b1) act_bits.push_back(cyc);
        if (bus.div_ack  === 1'b1) act_acks.push_back(cyc);
    end

    // ---------------- driver tasks / helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int di, input int df);
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.div_load = 1'b1;
        tick(1);
        bus.div_load = 1'b0;
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_logs();
        act_ticks.delete(); act_bits.delete(); act_acks.delete();
    endtask

    function automatic int gap(input int q[$], input int i);
        if (i >= 1 && i < q.size()) return q[i] - q[i-1];
        return -1;
    endfunction

    function automatic int first_ge(input int q[$], input int e);
        foreach (q[i]) if (q[i] >= e) return q[i];
        return -100000;
    endfunction

    function automatic int count_ge(input int q[$], input int e);
        int n = 0;
        foreach (q[i]) if (q[i] >= e) n++;
        return n;
    endfunction

    function automatic int index_of(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        baud_div_t ref_div;
        int e0, e_on, e_off, k, s;
        ref_div = baud_div_calc(64'd100_000_000, 64'd9600, 64'd16);

        rst = 1'b0; ps = 1'b0;
        bus.en = 1'b1; bus.div_load = 1'b0; bus.div_int = '0; bus.div_frac = '0;

        // Reset held 3 clocks with en=1: outputs stay low.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("reset_outputs", int'({bus.os_tick, bus.bit_tick, bus.div_ack}), 0);
        end
        rst = 1'b1;
        e0 = cyc + 1;
        clear_logs();
        tick(660);
        check_eq("first_tick_after_reset", first_ge(act_ticks, e0) - e0 + 1, int'(ref_div.div_int));

        // Integer divisor 4/0, loaded while stopped.
        bus.en = 1'b0;
        load(4, 0);
        tick(2);
        clear_logs();
        bus.en = 1'b1;
        e_on = cyc + 1;
        tick(200);
        check_eq("int_first_tick", first_ge(act_ticks, e_on) - e_on + 1, 4);
        for (int i = 1; i <= 4; i++) check_eq("int_period", gap(act_ticks, i), 4);
        check_eq("int_bit_period", gap(act_bits, 1), 64);

        // Fraction 4/8: alternate 4/5, 16 periods span 72 clocks.
        bus.en = 1'b0;
        load(4, 8);
        tick(2);
        clear_logs();
        bus.en = 1'b1;
        tick(100);
        check_eq("frac_pair", gap(act_ticks, 2) + gap(act_ticks, 3), 9);
        if (act_ticks.size() > 17) check_eq("frac_16_periods", act_ticks[17] - act_ticks[1], 72);
        else                       check_eq("frac_tick_count", act_ticks.size(), 18);

        // Reload 10/0 in the middle of a 4/0 stream.
        bus.en = 1'b0;
        load(4, 0);
        bus.en = 1'b1;
        tick(10);
        clear_logs();
        tick(6);
        load(10, 0);
        tick(30);
        check_eq("reload_ack_count", act_acks.size(), 1);
        k = (act_acks.size() > 0) ? index_of(act_ticks, act_acks[0]) : -1;
        check_eq("reload_ack_on_tick", (k >= 1) ? 1 : 0, 1);
        check_eq("reload_old_period", gap(act_ticks, k), 4);
        check_eq("reload_new_period", gap(act_ticks, k + 1), 10);

        // Boundary: divisor 0 clamps to a 2-clock period.
        bus.en = 1'b0;
        load(0, 0);
        bus.en = 1'b1;
        clear_logs();
        tick(20);
        check_eq("clamp_period_a", gap(act_ticks, 2), 2);
        check_eq("clamp_period_b", gap(act_ticks, 5), 2);

        // en dropped for 5 clocks mid-period, then restarted.
        bus.en = 1'b0;
        load(5, 0);
        bus.en = 1'b1;
        tick(12);
        bus.en = 1'b0;
        e_off = cyc + 1;
        clear_logs();
        tick(5);
        check_eq("en_off_no_ticks", count_ge(act_ticks, e_off), 0);
        bus.en = 1'b1;
        e_on = cyc + 1;
        tick(10);
        check_eq("en_restart_first_tick", first_ge(act_ticks, e_on) - e_on + 1, 5);

`ifdef BAUD_PHASE_SYNC_EN
        // Phase sync mid-bit: next bit_tick exactly 64 clocks later.
        bus.en = 1'b0;
        load(4, 0);
        bus.en = 1'b1;
        tick(37);
        clear_logs();
        ps = 1'b1;
        s = cyc + 1;
        tick(1);
        ps = 1'b0;
        tick(80);
        check_eq("sync_bit_tick", first_ge(act_bits, s) - s, 64);
`else
        s = 0;
`endif

        // Reset in the middle of a pending load: default 651/1 is restored.
        bus.en = 1'b1;
        load(9, 3);
        rst = 1'b0;
        tick(2);
        clear_logs();
        rst = 1'b1;
        e0 = cyc + 1;
        tick(660);
        check_eq("midrun_reset_first_tick", first_ge(act_ticks, e0) - e0 + 1, 651);
        check_eq("midrun_reset_no_ack", act_acks.size(), 0);

        // Randomized traffic, checked by the scoreboard only.
        for (int it = 0; it < 40; it++) begin
            tick($urandom_range(1, 30));
            case ($urandom_range(0, 7))
                0, 1, 2: load($urandom_range(0, 9), $urandom_range(0, 15));
                3:       bus.en = ~bus.en;
                4:       begin load($urandom_range(0, 9), $urandom_range(0, 15));
                               load($urandom_range(0, 9), $urandom_range(0, 15)); end
`ifdef BAUD_PHASE_SYNC_EN
                5:       begin ps = 1'b1; tick(1); ps = 1'b0; end
`endif
                default: bus.en = 1'b1;
            endcase
        end
        bus.en = 1'b1;
        tick(60);

        bus.en = 1'b0;
        tick(4);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
